pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/stall sequencer for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards between the ID and EX stages and inserts bubbles.
//  - Freezes the whole pipe while data memory is not ready; flushes on taken branches.
//  - Drives write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM.
// PARAMETERS
//  REG_W       5   register-index width
//  XZR_IDX     31  zero register; never causes a hazard
//  MEM_TIMEOUT 16  max consecutive not-ready wait cycles before error (>=2)
//  CNT_W       32  perf-counter width (only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk            in  1      system clock, rising edge
//  Reset          in  1      synchronous, active-low reset
//  Rn_De          in  REG_W  source register Rn of the instruction in ID
//  Rm_De          in  REG_W  source register Rm of the instruction in ID
//  UsesRm_De      in  1      ID instruction reads Rm (R-format, STUR, CBZ Rt)
//  Rd_Ex          in  REG_W  destination register of the instruction in EX
//  MemRead_Ex     in  1      EX instruction is a load (LDUR)
//  BranchTaken_Me in  1      branch resolved taken in MEM
//  DMemReq_Me     in  1      MEM stage is issuing a data-memory access
//  DMemReady      in  1      data memory completes the access this cycle
//  PCWrite        out 1      PC register update enable
//  IFID_Write     out 1      IF/ID register load enable
//  IFID_Flush     out 1      clear IF/ID to NOP
//  IDEX_Bubble    out 1      zero ID/EX control bits
//  EXMEM_Flush    out 1      zero EX/MEM control bits
//  PipeFreeze     out 1      hold ID/EX, EX/MEM, MEM/WB; MEM/WB RegWrite masked
//  MemError       out 1      sticky memory-timeout error
// BEHAVIOUR
//  - Reset=0 at a clk edge: state<=RUN, wait_cnt<=0, MemError<=0, counters<=0.
//    While Reset=0, outputs are forced: PCWrite=0, IFID_Write=0, IFID_Flush=1,
//    IDEX_Bubble=1, EXMEM_Flush=1, PipeFreeze=0, MemError=0.
//  - FSM states: RUN, MEM_WAIT, MEM_ERR. Outputs are Mealy (state + inputs), 0-cycle latency.
//  - load_use = MemRead_Ex & Rd_Ex!=XZR_IDX & (Rd_Ex==Rn_De | (UsesRm_De & Rd_Ex==Rm_De)).
//  - RUN, priority high to low:
//    1. DMemReq_Me & !DMemReady: PipeFreeze=1, PCWrite=0, IFID_Write=0; wait_cnt<=1;
//       next state MEM_WAIT. A taken branch or load-use in the same cycle is deferred;
//       the frozen stages re-present them.
//    2. BranchTaken_Me: IFID_Flush=1, IDEX_Bubble=1, EXMEM_Flush=1, PCWrite=1, IFID_Write=1.
//       Load-use in the same cycle is ignored because the instruction is flushed.
//    3. load_use: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Exactly one bubble per hazard,
//       since the load has moved to MEM on the next cycle.
//    4. Otherwise: PCWrite=1, IFID_Write=1, all other controls 0.
//    - DMemReq_Me & DMemReady in RUN is a single-cycle access: no freeze.
//  - MEM_WAIT:
//    - !DMemReady: freeze outputs as in RUN(1); wait_cnt++. If wait_cnt==MEM_TIMEOUT-1,
//      next state MEM_ERR and MemError<=1.
//    - DMemReady: freeze released this cycle; evaluate RUN rules 2-4 this cycle;
//      next state RUN; wait_cnt<=0.
//  - MEM_ERR: PipeFreeze=1, PCWrite=0, IFID_Write=0, MemError=1. Exit only via Reset.
//  - wait_cnt is $clog2(MEM_TIMEOUT)+1 bits and never wraps.
//  - Reset mid-MEM_WAIT: freeze drops on the next cycle; the pending access is abandoned.
// CONFIGURATION
//  - HAZARD_PERF_CNT_EN defined: adds outputs LoadUseCnt, FreezeCnt, FlushCnt (CNT_W each).
//    - Each counts cycles with IDEX_Bubble from load-use, with PipeFreeze, and with
//      BranchTaken flush, respectively.
//    - Counters saturate at all-ones and clear on reset.
//  - Undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared header legv8_defs.vh: FSM state encodings (RUN=2'd0, MEM_WAIT=2'd1,
//    MEM_ERR=2'd2), XZR index, REG_W.
//  - Sub-module sat_counter (CNT_W, inc, clear), instantiated 3x under HAZARD_PERF_CNT_EN.
// TESTING
//  - Reset: hold Reset=0 for 2 cycles -> IFID_Flush=1, PCWrite=0; release -> RUN,
//    PCWrite=1, MemError=0.
//  - Load-use: MemRead_Ex=1, Rd_Ex=3, Rn_De=3 -> one cycle with PCWrite=0, IDEX_Bubble=1.
//    Same with Rd_Ex=31 -> no stall.
//  - Rm path: Rd_Ex=5, Rm_De=5, UsesRm_De=0 -> no stall; UsesRm_De=1 -> stall.
//  - Branch and load-use together: BranchTaken_Me=1 with load_use=1 -> IFID_Flush=1,
//    IDEX_Bubble=1, EXMEM_Flush=1, PCWrite=1.
//  - Memory wait: DMemReq_Me=1, DMemReady low 3 cycles then high -> PipeFreeze=1 for
//    exactly 3 cycles, 0 on the ready cycle; state back to RUN.
//  - Timeout: DMemReady held 0 with MEM_TIMEOUT=16 -> MemError=1 after 16 freeze
//    cycles, stuck until Reset; with HAZARD_PERF_CNT_EN, FreezeCnt increments every
//    frozen cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the LEGv8 hazard/stall sequencer.
// The FSM state encoding and the control-bundle presets live here.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W_DEF       = 5;
  localparam int XZR_IDX_DEF     = 31;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_STALL   = '{idex_bubble: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pipe_freeze: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_RESET   = '{ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1,
                                     default: 1'b0};
  localparam ctrl_t CTRL_BRANCH  = '{pipe_freeze: 1'b0, default: 1'b1};

  // Branch beats load-use: the dependent instruction is being flushed anyway.
  function automatic ctrl_t resolve_ctrl(input logic branch_taken, input logic load_use);
    if (branch_taken)  return CTRL_BRANCH;
    else if (load_use) return CTRL_STALL;
    else               return CTRL_ADVANCE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for hazard perf counters
// (instantiated only when HAZARD_PERF_CNT_EN is defined).
module pipeline_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage LEGv8 pipe: load-use bubbles, memory
// freeze with timeout, branch flush. Optional perf counters via HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int XZR_IDX     = XZR_IDX_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] Rn_De,
  input  logic [REG_W-1:0] Rm_De,
  input  logic             UsesRm_De,
  input  logic [REG_W-1:0] Rd_Ex,
  input  logic             MemRead_Ex,
  input  logic             BranchTaken_Me,
  input  logic             DMemReq_Me,
  input  logic             DMemReady,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Flush,
  output logic             PipeFreeze,
  output logic             MemError
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] FreezeCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            load_use;
  ctrl_t           ctrl;

  assign load_use = MemRead_Ex && (Rd_Ex != REG_W'(XZR_IDX)) &&
                    ((Rd_Ex == Rn_De) || (UsesRm_De && (Rd_Ex == Rm_De)));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl       = CTRL_ADVANCE;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;

    unique case (state_q)
      ST_RUN: begin
        if (DMemReq_Me && !DMemReady) begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = WC_W'(1);
          state_d    = ST_MEM_WAIT;
        end else begin
          ctrl = resolve_ctrl(BranchTaken_Me, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (!DMemReady) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WC_LAST) begin
            state_d   = ST_MEM_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          ctrl       = resolve_ctrl(BranchTaken_Me, load_use);
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_ERR: ctrl = CTRL_FREEZE;
      default:    state_d = ST_RUN;
    endcase

    if (!Reset) begin
      ctrl = CTRL_RESET;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IFID_Write  = ctrl.ifid_write;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign IDEX_Bubble = ctrl.idex_bubble;
  assign EXMEM_Flush = ctrl.exmem_flush;
  assign PipeFreeze  = ctrl.pipe_freeze;
  assign MemError    = Reset && mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  // Reset drives flush+bubble too, so it must be masked out of the event decode.
  logic lu_evt, fl_evt;
  assign lu_evt = Reset && IDEX_Bubble && !IFID_Flush;
  assign fl_evt = Reset && IFID_Flush;

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk(clk), .clear_i(!Reset), .inc_i(lu_evt), .cnt_o(LoadUseCnt)
  );
  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_fz_cnt (
    .clk(clk), .clear_i(!Reset), .inc_i(PipeFreeze), .cnt_o(FreezeCnt)
  );
  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_fl_cnt (
    .clk(clk), .clear_i(!Reset), .inc_i(fl_evt), .cnt_o(FlushCnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases plus random stimulus
// against a cycle-level behavioural model; checks perf counters if HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] Rn_De, Rm_De, Rd_Ex;
  logic       UsesRm_De, MemRead_Ex, BranchTaken_Me, DMemReq_Me, DMemReady;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush, PipeFreeze, MemError;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] LoadUseCnt, FreezeCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .Reset(Reset),
    .Rn_De(Rn_De), .Rm_De(Rm_De), .UsesRm_De(UsesRm_De), .Rd_Ex(Rd_Ex),
    .MemRead_Ex(MemRead_Ex), .BranchTaken_Me(BranchTaken_Me),
    .DMemReq_Me(DMemReq_Me), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Flush(EXMEM_Flush), .PipeFreeze(PipeFreeze),
    .MemError(MemError)
`ifdef HAZARD_PERF_CNT_EN
    , .LoadUseCnt(LoadUseCnt), .FreezeCnt(FreezeCnt), .FlushCnt(FlushCnt)
`endif
  );

  // Expected bundle: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush, PipeFreeze, MemError}
  typedef struct {
    logic [6:0] ctrl;
    bit         cnt_known;
    longint     lu, fz, fl;
    int         cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc_no   = 0;

  // Model state: number of consecutive frozen cycles so far, sticky error, counters.
  int     m_frozen = 0;
  bit     m_err    = 1'b0;
  bit     m_known  = 1'b0;
  longint m_lu = 0, m_fz = 0, m_fl = 0;

  task automatic check(input string name, input longint got, input longint exp, input int cyc);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input int rn, input int rm, input bit urm, input int rd,
                       input bit mr, input bit br, input bit req, input bit rdy);
    exp_t       e;
    logic [6:0] o;
    bit         lu;
    bit         frz   = 1'b0;
    bit         stall = 1'b0;
    bit         flush = 1'b0;
    @(posedge clk);
    #1;
    Reset = rst; Rn_De = 5'(rn); Rm_De = 5'(rm); UsesRm_De = urm; Rd_Ex = 5'(rd);
    MemRead_Ex = mr; BranchTaken_Me = br; DMemReq_Me = req; DMemReady = rdy;

    lu = mr && (rd != 31) && ((rd == rn) || (urm && (rd == rm)));
    e.cnt_known = m_known; e.lu = m_lu; e.fz = m_fz; e.fl = m_fl; e.cyc = cyc_no++;

    if (!rst) begin
      o = 7'b0011100; m_frozen = 0; m_err = 1'b0;
    end else if (m_err) begin
      o = 7'b0000011; frz = 1'b1;
    end else if ((m_frozen > 0 && !rdy) || (m_frozen == 0 && req && !rdy)) begin
      o = 7'b0000010; frz = 1'b1;
      m_frozen++;
      if (m_frozen == MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      m_frozen = 0;
      if (br)      begin o = 7'b1111100; flush = 1'b1; end
      else if (lu) begin o = 7'b0001000; stall = 1'b1; end
      else         o = 7'b1100000;
    end
    e.ctrl = o;
    sb.push_back(e);

    if (!rst) begin
      m_known = 1'b1; m_lu = 0; m_fz = 0; m_fl = 0;
    end else begin
      m_lu += longint'(stall); m_fz += longint'(frz); m_fl += longint'(flush);
    end
  endtask

  task automatic idle(input bit rst);
    drive(rst, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic int pick_reg();
    int r = int'($urandom_range(0, 4));
    return (r == 4) ? 31 : r;
  endfunction

  // Monitor: outputs are valid every cycle; compare mid-cycle, away from posedge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctrl", longint'({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush,
                                PipeFreeze, MemError}), longint'(e.ctrl), e.cyc);
`ifdef HAZARD_PERF_CNT_EN
        if (e.cnt_known) begin
          check("LoadUseCnt", longint'(LoadUseCnt), e.lu, e.cyc);
          check("FreezeCnt",  longint'(FreezeCnt),  e.fz, e.cyc);
          check("FlushCnt",   longint'(FlushCnt),   e.fl, e.cyc);
        end
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Rn_De = '0; Rm_De = '0; UsesRm_De = 1'b0; Rd_Ex = '0;
    MemRead_Ex = 1'b0; BranchTaken_Me = 1'b0; DMemReq_Me = 1'b0; DMemReady = 1'b0;

    idle(1'b0); idle(1'b0);
    idle(1'b1);
    // Load-use on Rn, then the load has moved on.
    drive(1'b1, 3, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3, 0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    // XZR destination never stalls.
    drive(1'b1, 31, 0, 1'b0, 31, 1'b1, 1'b0, 1'b0, 1'b1);
    // Rm path gated by UsesRm_De.
    drive(1'b1, 0, 5, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 0, 5, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    // Branch with simultaneous load-use.
    drive(1'b1, 3, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1);
    // Single-cycle access, then a 3-cycle wait with a deferred branch.
    drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    // Timeout: error after MEM_TIMEOUT freeze cycles, sticky even once ready returns.
    repeat (MEM_TIMEOUT + 4) drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    // Reset in the middle of a memory wait abandons it.
    repeat (3) drive(1'b1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) >= 2, pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
            pick_reg(), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
